mac_rx_fifo_reader: RTL
=======================

Name: mac_rx_fifo_reader

Overview:
- Consumer side of the tri-mode MAC receive FIFO interface.
- Drains packets from the MAC with a read-request handshake and writes 32-bit words into a word-addressed packet buffer (RAM toward the AXI read path).
- Emits one descriptor per packet: start address, byte length, error flag.
- Throttles the MAC when the buffer has too little free space.

Parameters:
- ADDR_W, 15, buffer word address width (32768 entries); addresses wrap modulo 2^ADDR_W.
- MAX_WORDS, 5000, maximum words per packet (20000 bytes); longer packets are truncated and flagged.
- RD_LAT, 2, maximum cycles the MAC may keep presenting mac_rxdv_i after mac_rxrqrd_o drops.

Ports:
- mac_clk_i  in  1  single clock for all logic.
- mac_rst_i  in  1  synchronous reset, active-high.
- mac_rxd_i  in  32  receive data word; byte 0 in [31:24].
- mac_ben_i  in  2  valid bytes in the EOP word: 00=4, 01=3, 10=2, 11=1. Ignored when mac_rxeop_i is low.
- mac_rxda_i  in  1  MAC FIFO holds data.
- mac_rxsop_i  in  1  start of packet; qualified by mac_rxdv_i.
- mac_rxeop_i  in  1  end of packet; qualified by mac_rxdv_i.
- mac_rxdv_i  in  1  word valid; always accepted, never back-pressured.
- mac_rxrqrd_o  out  1  read request to the MAC.
- buf_free_i  in  ADDR_W+1  free words in the buffer (supplied by the buffer's read side).
- buf_wr_en_o  out  1  buffer write strobe.
- buf_wr_addr_o  out  ADDR_W  buffer write address.
- buf_wr_data_o  out  32  buffer write data.
- pkt_done_o  out  1  one-cycle descriptor valid strobe.
- pkt_addr_o  out  ADDR_W  packet start word address.
- pkt_len_o  out  16  packet length in bytes.
- pkt_err_o  out  1  packet truncated, or aborted by an early SOP.
- pkt_cnt_o  out  32  count of good packets; wraps.
- drop_cnt_o  out  32  count of errored packets; wraps.

Behaviour:
- Reset: all outputs 0, write pointer 0, state IDLE. Reset mid-packet discards the partial packet and issues no descriptor.
- States:
  - IDLE: waiting for data.
  - READING: requesting and accepting words.
  - HALT: buffer too full, request dropped.
  - DROP: consuming the rest of an over-length packet.
- mac_rxrqrd_o is registered. It is 1 in READING and DROP when mac_rxda_i=1, and 0 otherwise.
- IDLE→READING when mac_rxda_i=1 and buf_free_i > RD_LAT+1.
- READING→HALT when buf_free_i <= RD_LAT+1. HALT→READING when buf_free_i > RD_LAT+1.
- Words with mac_rxdv_i=1 are accepted in every state, including HALT and the RD_LAT tail after the request drops.
- Outside a packet, mac_rxdv_i without SOP: word discarded, no write, no count.
- Write latency: an accepted word appears on buf_wr_en_o/addr/data exactly 1 cycle after mac_rxdv_i. The address post-increments and wraps from 2^ADDR_W-1 to 0.
- SOP: latch pkt_addr = current write pointer; clear the word counter.
- SOP and EOP on the same word: a one-word packet, length = ben bytes.
- Length = 4*(words-1) + bytes(ben) at EOP.
- Descriptor: pkt_done_o pulses in the same cycle as the EOP word's buf_wr_en_o. pkt_addr_o, pkt_len_o and pkt_err_o are held until the next pkt_done_o.
- Word MAX_WORDS+1 in a packet: writes stop and the state moves to DROP. DROP consumes to EOP, then issues a descriptor with pkt_len_o = 4*MAX_WORDS and pkt_err_o=1.
- SOP while a packet is open:
  - Close the open packet as an error, with length = 4*words so far.
  - Its descriptor strobes on the cycle the new SOP word is written.
  - The new packet starts on that word.
- pkt_cnt_o increments on a descriptor with err=0. drop_cnt_o increments on a descriptor with err=1.
- Reaching EOP while mac_rxda_i=0 → IDLE. Otherwise stay in READING.

Test Plan:
- Single packet, 5 words (0xA0000000..4), ben=10 on EOP, buf_free_i=100:
  - writes at addr 0..4, each 1 cycle after its rxdv;
  - pkt_done_o on the 5th write, pkt_addr_o=0, pkt_len_o=18, pkt_err_o=0, pkt_cnt_o=1.
- Back-to-back one-word packets (SOP+EOP, ben 00 then 11):
  - two descriptors: len 4 at addr 0, then len 1 at addr 1.
- buf_free_i stepped 10→3 with RD_LAT=2 mid-packet:
  - mac_rxrqrd_o falls next cycle;
  - 2 trailing rxdv words still written;
  - buf_free_i=4 resumes READING;
  - final length correct, no word lost.
- 5001-word packet, MAX_WORDS=5000:
  - 5000 writes;
  - pkt_len_o=20000, pkt_err_o=1, drop_cnt_o=1;
  - next packet starts at addr 5000.
- Write pointer preset near 32767, 3-word packet:
  - writes at 32767, 0, 1;
  - pkt_addr_o=32767.
- SOP arrives after 3 words with no EOP: error descriptor, len 12, addr 0; new packet starts at addr 3.
- Reset asserted at word 2 of a packet: all outputs 0 next cycle, no descriptor; next packet writes from addr 0.

Source files
------------

// File: rtl/mac_rx_fifo_reader.sv
// MAC receive FIFO consumer: drains packets into a word buffer and
// emits one descriptor (start address, byte length, error) per packet.
module mac_rx_fifo_reader #(
    parameter int ADDR_W    = 15,
    parameter int MAX_WORDS = 5000,
    parameter int RD_LAT    = 2
) (
    input  logic              mac_clk_i,
    input  logic              mac_rst_i,
    input  logic [31:0]       mac_rxd_i,
    input  logic [1:0]        mac_ben_i,
    input  logic              mac_rxda_i,
    input  logic              mac_rxsop_i,
    input  logic              mac_rxeop_i,
    input  logic              mac_rxdv_i,
    output logic              mac_rxrqrd_o,
    input  logic [ADDR_W:0]   buf_free_i,
    output logic              buf_wr_en_o,
    output logic [ADDR_W-1:0] buf_wr_addr_o,
    output logic [31:0]       buf_wr_data_o,
    output logic              pkt_done_o,
    output logic [ADDR_W-1:0] pkt_addr_o,
    output logic [15:0]       pkt_len_o,
    output logic              pkt_err_o,
    output logic [31:0]       pkt_cnt_o,
    output logic [31:0]       drop_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_HALT,
        S_DROP
    } state_t;

    localparam logic [ADDR_W:0] THR    = (ADDR_W+1)'(RD_LAT + 1);
    localparam logic [15:0]     WMAX   = 16'(MAX_WORDS);
    localparam logic [15:0]     MAXLEN = 16'(4 * MAX_WORDS);

    state_t            r_state;
    state_t            w_next;
    logic              r_rqrd;
    logic              w_rqrd_d;

    logic              r_in_pkt;
    logic [15:0]       r_wcnt;
    logic [ADDR_W-1:0] r_start;
    logic [ADDR_W-1:0] r_wptr;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_done;
    logic [ADDR_W-1:0] r_pkt_addr;
    logic [15:0]       r_pkt_len;
    logic              r_pkt_err;
    logic [31:0]       r_pkt_cnt;
    logic [31:0]       r_drop_cnt;

    logic              w_room;
    logic              w_sop;
    logic              w_eop;
    logic              w_trunc;
    logic              w_wr;
    logic              w_close;
    logic              w_abort;
    logic              w_desc;
    logic [2:0]        w_bytes;
    logic [ADDR_W-1:0] w_d_addr;
    logic [15:0]       w_d_len;
    logic              w_d_err;
    logic              w_good_inc;
    logic              w_drop_inc;

    assign w_room  = buf_free_i > THR;
    assign w_sop   = mac_rxdv_i && mac_rxsop_i;
    assign w_eop   = mac_rxdv_i && mac_rxeop_i;
    assign w_trunc = mac_rxdv_i && r_in_pkt && !mac_rxsop_i && (r_wcnt == WMAX);
    assign w_wr    = w_sop || (mac_rxdv_i && r_in_pkt && !w_trunc);
    assign w_close = w_eop && (r_in_pkt || w_sop);
    assign w_abort = w_sop && r_in_pkt;
    assign w_desc  = w_close || w_abort;
    assign w_bytes = 3'd4 - {1'b0, mac_ben_i};

    // An SOP+EOP word that also aborts an open packet reports only the new
    // one-word packet; the aborted one is still counted in drop_cnt.
    always_comb begin
        w_d_addr = r_start;
        w_d_len  = r_wcnt << 2;
        w_d_err  = 1'b1;
        if (w_close) begin
            if (w_sop) begin
                w_d_addr = r_wptr;
                w_d_len  = {13'd0, w_bytes};
                w_d_err  = 1'b0;
            end else if (w_trunc) begin
                w_d_len  = MAXLEN;
            end else begin
                w_d_len  = (r_wcnt << 2) + {13'd0, w_bytes};
                w_d_err  = 1'b0;
            end
        end
    end

    assign w_good_inc = w_close && !w_trunc;
    assign w_drop_inc = w_abort || (w_close && w_trunc);

    always_ff @(posedge mac_clk_i) begin
        if (mac_rst_i) begin
            r_state <= S_IDLE;
            r_rqrd  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rqrd  <= w_rqrd_d;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (mac_rxda_i && w_room) w_next = S_READ;
            S_READ: begin
                if (w_eop && !mac_rxda_i) w_next = S_IDLE;
                else if (!w_room)         w_next = S_HALT;
            end
            S_HALT: if (w_room) w_next = S_READ;
            S_DROP: begin
                if (w_eop)      w_next = mac_rxda_i ? S_READ : S_IDLE;
                else if (w_sop) w_next = S_READ;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_trunc && !w_eop) w_next = S_DROP;
    end

    always_comb begin
        w_rqrd_d = mac_rxda_i && ((w_next == S_READ) || (w_next == S_DROP));
    end

    always_ff @(posedge mac_clk_i) begin
        if (mac_rst_i) begin
            r_in_pkt   <= 1'b0;
            r_wcnt     <= '0;
            r_start    <= '0;
            r_wptr     <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
            r_pkt_addr <= '0;
            r_pkt_len  <= '0;
            r_pkt_err  <= 1'b0;
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_sop) begin
                r_in_pkt <= !mac_rxeop_i;
                r_wcnt   <= 16'd1;
                r_start  <= r_wptr;
            end else if (w_eop) begin
                r_in_pkt <= 1'b0;
            end else if (w_wr) begin
                r_wcnt   <= r_wcnt + 16'd1;
            end
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            r_wr_en   <= w_wr;
            r_wr_addr <= r_wptr;
            r_wr_data <= mac_rxd_i;
            r_done    <= w_desc;
            if (w_desc) begin
                r_pkt_addr <= w_d_addr;
                r_pkt_len  <= w_d_len;
                r_pkt_err  <= w_d_err;
            end
            if (w_good_inc) r_pkt_cnt  <= r_pkt_cnt + 32'd1;
            if (w_drop_inc) r_drop_cnt <= r_drop_cnt + 32'd1;
        end
    end

    assign mac_rxrqrd_o  = r_rqrd;
    assign buf_wr_en_o   = r_wr_en;
    assign buf_wr_addr_o = r_wr_addr;
    assign buf_wr_data_o = r_wr_data;
    assign pkt_done_o    = r_done;
    assign pkt_addr_o    = r_pkt_addr;
    assign pkt_len_o     = r_pkt_len;
    assign pkt_err_o     = r_pkt_err;
    assign pkt_cnt_o     = r_pkt_cnt;
    assign drop_cnt_o    = r_drop_cnt;

endmodule
